pos_goal_monitor: RTL

Downstream consumer of the pose accumulator stage. Samples the accumulated pose (POSX, POSY, THETA) once per accumulator load tick and computes the signed error to a commanded goal pose, with heading error wrapped to ±180°. A dwell-qualified state machine decides arrival and drives a ready/valid goal-load handshake toward the trajectory sequencer. All data is 17-bit sign-magnitude fixed point, Q8: bit 16 is the sign, bits 15:0 are the magnitude.

---
 rtl/pos_goal_monitor_if.sv | 37 +++
 rtl/pos_goal_monitor.sv | 109 ++++++++++
 2 files changed

// File: rtl/pos_goal_monitor_if.sv
// pos_goal_monitor_if: tick, pose, goal handshake and error outputs of the goal monitor
interface pos_goal_monitor_if #(parameter int N_WIDTH = 17);
  logic               POS_GOAL_MONITOR_TICKLOAD_InLow;
  logic               POS_GOAL_MONITOR_SETBEGIN_InLow;
  logic               POS_GOAL_MONITOR_ABORT_InLow;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_POSX_InBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_POSY_InBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_THETA_InBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_GOALX_InBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_GOALY_InBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_GOALTHETA_InBus;
  logic               POS_GOAL_MONITOR_GOALVALID_InHigh;
  logic               POS_GOAL_MONITOR_GOALREADY_OutHigh;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_ERRX_OutBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_ERRY_OutBus;
  logic [N_WIDTH-1:0] POS_GOAL_MONITOR_ERRTHETA_OutBus;
  logic               POS_GOAL_MONITOR_BUSY_OutHigh;
  logic               POS_GOAL_MONITOR_ARRIVED_OutHigh;
  modport master (
    output POS_GOAL_MONITOR_TICKLOAD_InLow, POS_GOAL_MONITOR_SETBEGIN_InLow, POS_GOAL_MONITOR_ABORT_InLow,
    output POS_GOAL_MONITOR_POSX_InBus, POS_GOAL_MONITOR_POSY_InBus, POS_GOAL_MONITOR_THETA_InBus,
    output POS_GOAL_MONITOR_GOALX_InBus, POS_GOAL_MONITOR_GOALY_InBus, POS_GOAL_MONITOR_GOALTHETA_InBus,
    output POS_GOAL_MONITOR_GOALVALID_InHigh,
    input  POS_GOAL_MONITOR_GOALREADY_OutHigh,
    input  POS_GOAL_MONITOR_ERRX_OutBus, POS_GOAL_MONITOR_ERRY_OutBus, POS_GOAL_MONITOR_ERRTHETA_OutBus,
    input  POS_GOAL_MONITOR_BUSY_OutHigh, POS_GOAL_MONITOR_ARRIVED_OutHigh
  );
  modport slave (
    input  POS_GOAL_MONITOR_TICKLOAD_InLow, POS_GOAL_MONITOR_SETBEGIN_InLow, POS_GOAL_MONITOR_ABORT_InLow,
    input  POS_GOAL_MONITOR_POSX_InBus, POS_GOAL_MONITOR_POSY_InBus, POS_GOAL_MONITOR_THETA_InBus,
    input  POS_GOAL_MONITOR_GOALX_InBus, POS_GOAL_MONITOR_GOALY_InBus, POS_GOAL_MONITOR_GOALTHETA_InBus,
    input  POS_GOAL_MONITOR_GOALVALID_InHigh,
    output POS_GOAL_MONITOR_GOALREADY_OutHigh,
    output POS_GOAL_MONITOR_ERRX_OutBus, POS_GOAL_MONITOR_ERRY_OutBus, POS_GOAL_MONITOR_ERRTHETA_OutBus,
    output POS_GOAL_MONITOR_BUSY_OutHigh, POS_GOAL_MONITOR_ARRIVED_OutHigh
  );
endinterface

// File: rtl/pos_goal_monitor.sv
// pos_goal_monitor: goal-pose error pipeline with dwell-qualified arrival FSM and goal-load handshake
module pos_goal_monitor #(
  parameter int                 N_WIDTH     = 17,
  parameter int                 Q_WIDTH     = 8,
  parameter logic [N_WIDTH-1:0] TOL_POS     = 17'd256,
  parameter logic [N_WIDTH-1:0] TOL_THETA   = 17'd512,
  parameter int                 DWELL_TICKS = 4
) (
  input logic               POS_GOAL_MONITOR_CLOCK_50,
  input logic               POS_GOAL_MONITOR_RESET_InLow,
  pos_goal_monitor_if.slave bus
);
  localparam int M = N_WIDTH - 1;
  localparam logic signed [N_WIDTH+1:0] HALF = (N_WIDTH+2)'(180 << Q_WIDTH);
  localparam logic signed [N_WIDTH+1:0] FULL = (N_WIDTH+2)'(360 << Q_WIDTH);
  localparam logic signed [N_WIDTH+1:0] MAXM = (N_WIDTH+2)'((1 << M) - 1);
  typedef enum logic [1:0] {IDLE, TRACK, SETTLE, ARRIVED} state_t;
  // goal minus pose in sign-magnitude; heading folded once into (-180, +180], magnitude saturated
  function automatic logic [N_WIDTH-1:0] err_calc(input logic [N_WIDTH-1:0] g, input logic [N_WIDTH-1:0] p, input logic wrap);
    logic signed [N_WIDTH+1:0] gs, ps, d, a;
    gs = g[M] ? -$signed({3'b0, g[M-1:0]}) : $signed({3'b0, g[M-1:0]});
    ps = p[M] ? -$signed({3'b0, p[M-1:0]}) : $signed({3'b0, p[M-1:0]});
    d = gs - ps;
    if (wrap && d > HALF) d = d - FULL;
    else if (wrap && d <= -HALF) d = d + FULL;
    a = d < 0 ? -d : d;
    return {d < 0, a > MAXM ? {M{1'b1}} : a[M-1:0]};
  endfunction
  state_t             state_q, state_d;
  logic [7:0]         dwell_q, dwell_d;
  logic               tick_prev_q, tick_prev_d, v1_q, v1_d, v2_q, v2_d;
  logic [N_WIDTH-1:0] pose_q [3], pose_d [3];
  logic [N_WIDTH-1:0] goal_q [3], goal_d [3];
  logic [N_WIDTH-1:0] err_q [3], err_d [3];
  logic               tick, clr, accept, in_tol, ready;
  // tick edge detect, pose capture (stage 1), error compute (stage 2), goal latch
  always_comb begin
    clr = !bus.POS_GOAL_MONITOR_SETBEGIN_InLow || !bus.POS_GOAL_MONITOR_ABORT_InLow;
    accept = bus.POS_GOAL_MONITOR_GOALVALID_InHigh && ready;
    tick = tick_prev_q && !bus.POS_GOAL_MONITOR_TICKLOAD_InLow;
    tick_prev_d = bus.POS_GOAL_MONITOR_TICKLOAD_InLow;
    v1_d = tick && state_q != IDLE && !clr && !accept;
    v2_d = v1_q && !clr && !accept;
    pose_d[0] = tick ? bus.POS_GOAL_MONITOR_POSX_InBus : pose_q[0];
    pose_d[1] = tick ? bus.POS_GOAL_MONITOR_POSY_InBus : pose_q[1];
    pose_d[2] = tick ? bus.POS_GOAL_MONITOR_THETA_InBus : pose_q[2];
    goal_d[0] = accept ? bus.POS_GOAL_MONITOR_GOALX_InBus : goal_q[0];
    goal_d[1] = accept ? bus.POS_GOAL_MONITOR_GOALY_InBus : goal_q[1];
    goal_d[2] = accept ? bus.POS_GOAL_MONITOR_GOALTHETA_InBus : goal_q[2];
    for (int i = 0; i < 3; i++)
      err_d[i] = clr ? '0 : (v1_q && !accept) ? err_calc(goal_q[i], pose_q[i], i == 2) : err_q[i];
    in_tol = {1'b0, err_q[0][M-1:0]} <= TOL_POS && {1'b0, err_q[1][M-1:0]} <= TOL_POS &&
             {1'b0, err_q[2][M-1:0]} <= TOL_THETA;
  end
  // arrival FSM next state: clear > accept > stage-3 evaluation
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (clr) begin
      state_d = IDLE;
      dwell_d = '0;
    end else if (accept) begin
      state_d = TRACK;
      dwell_d = '0;
    end else if (v2_q && state_q != IDLE && !in_tol) begin
      state_d = TRACK;
      dwell_d = '0;
    end else if (v2_q && (state_q == TRACK || state_q == SETTLE)) begin
      dwell_d = dwell_q + 8'd1;
      state_d = dwell_d == 8'(DWELL_TICKS) ? ARRIVED : SETTLE;
    end
  end
  // status and handshake decode
  always_comb begin
    bus.POS_GOAL_MONITOR_BUSY_OutHigh = state_q == TRACK || state_q == SETTLE;
    bus.POS_GOAL_MONITOR_ARRIVED_OutHigh = state_q == ARRIVED;
    ready = POS_GOAL_MONITOR_RESET_InLow && !clr && (state_q == IDLE || state_q == ARRIVED);
    bus.POS_GOAL_MONITOR_GOALREADY_OutHigh = ready;
    bus.POS_GOAL_MONITOR_ERRX_OutBus = err_q[0];
    bus.POS_GOAL_MONITOR_ERRY_OutBus = err_q[1];
    bus.POS_GOAL_MONITOR_ERRTHETA_OutBus = err_q[2];
  end
  // state register
  always_ff @(posedge POS_GOAL_MONITOR_CLOCK_50) begin
    if (!POS_GOAL_MONITOR_RESET_InLow) begin
      state_q <= IDLE;
      dwell_q <= '0;
      tick_prev_q <= 1'b1;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pose_q[i] <= '0;
        goal_q[i] <= '0;
        err_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      tick_prev_q <= tick_prev_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      for (int i = 0; i < 3; i++) begin
        pose_q[i] <= pose_d[i];
        goal_q[i] <= goal_d[i];
        err_q[i] <= err_d[i];
      end
    end
  end
endmodule
